// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forwarding selects
// and the hard-wired zero register.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun      = 2'b00,
        StMemWait  = 2'b01,
        StIrqDrain = 2'b10,
        StIrqEnter = 2'b11
    } state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Combinational forwarding comparator for one ALU operand; the younger EX/MEM result
// wins over MEM/WB, and writes to the zero register are never forwarded.
module pipe_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_src,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_wr_reg,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_wr_reg,
    output logic [1:0] fwd_sel
);

    logic mem_hit;
    logic wb_hit;

    always_comb begin
        mem_hit = mem_reg_write && (mem_wr_reg != REG_ZERO) && (mem_wr_reg == ex_src);
        wb_hit  = wb_reg_write && (wb_wr_reg != REG_ZERO) && (wb_wr_reg == ex_src);
        if (mem_hit) begin
            fwd_sel = FWD_EXMEM;
        end else if (wb_hit) begin
            fwd_sel = FWD_MEMWB;
        end else begin
            fwd_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencer: stalls, flushes, memory freeze, interrupt drain/entry,
// EX forwarding selects and saturating stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_wr_reg,
    input  logic             ex_branch_taken,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_wr_reg,
    input  logic             mem_access,
    input  logic             mem_ready,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_wr_reg,
    input  logic             irq,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             irq_take,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [2:0]       DrainInit = 3'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax    = '1;

    state_e           state_q, state_d;
    logic             irq_pend_q, irq_pend_d;
    logic [2:0]       drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       load_use;
    logic       mem_stall;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    // A load always writes its destination, so load_use keys on ex_mem_read alone.
    logic unused_ex_reg_write;
    assign unused_ex_reg_write = ex_reg_write;

    pipe_fwd_unit u_fwd_a (
        .ex_src        (ex_rs),
        .mem_reg_write (mem_reg_write),
        .mem_wr_reg    (mem_wr_reg),
        .wb_reg_write  (wb_reg_write),
        .wb_wr_reg     (wb_wr_reg),
        .fwd_sel       (fwd_a_raw)
    );

    pipe_fwd_unit u_fwd_b (
        .ex_src        (ex_rt),
        .mem_reg_write (mem_reg_write),
        .mem_wr_reg    (mem_wr_reg),
        .wb_reg_write  (wb_reg_write),
        .wb_wr_reg     (wb_wr_reg),
        .fwd_sel       (fwd_b_raw)
    );

    always_comb begin
        load_use  = ex_mem_read && (ex_wr_reg != REG_ZERO) &&
                    ((ex_wr_reg == id_rs) || (id_uses_rt && (ex_wr_reg == id_rt)));
        mem_stall = mem_access && !mem_ready;
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_hold   = 1'b0;
        irq_take    = 1'b0;
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        irq_pend_d  = irq_pend_q;

        if (irq && ((state_q == StRun) || (state_q == StMemWait))) begin
            irq_pend_d = 1'b1;
        end

        unique case (state_q)
            StRun: begin
                if (mem_stall) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                    state_d    = StMemWait;
                end else begin
                    if (ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end else if (id_jump) begin
                        ifid_flush = 1'b1;
                    end
                    // A taken branch must redirect fetch before the drain starts.
                    if (irq_pend_q && !ex_branch_taken) begin
                        state_d     = StIrqDrain;
                        drain_cnt_d = DrainInit;
                    end
                end
            end
            StMemWait: begin
                if (!mem_ready) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                end else begin
                    state_d = StRun;
                end
            end
            StIrqDrain: begin
                pc_write   = 1'b0;
                ifid_flush = 1'b1;
                if (mem_stall) begin
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q - 3'd1;
                    if (drain_cnt_q <= 3'd1) begin
                        state_d = StIrqEnter;
                    end
                end
            end
            StIrqEnter: begin
                irq_take   = 1'b1;
                ifid_flush = 1'b1;
                irq_pend_d = 1'b0;
                state_d    = StRun;
            end
            default: state_d = StRun;
        endcase

        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pipe_hold  = 1'b0;
            irq_take   = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + CntOne;
        end
        flush_cnt_d = flush_cnt_q;
        if (ifid_flush && (flush_cnt_q != CntMax)) begin
            flush_cnt_d = flush_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            irq_pend_q  <= 1'b0;
            drain_cnt_q <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            irq_pend_q  <= irq_pend_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign forward_a = reset ? FWD_RF : fwd_a_raw;
    assign forward_b = reset ? FWD_RF : fwd_b_raw;
    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a RUN-state vector table plus hand-written
// sequences for reset, load-use, memory freeze, branch flush and interrupt drain.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_wr_reg, mem_wr_reg, wb_wr_reg;
    logic        id_uses_rt, id_jump, ex_reg_write, ex_mem_read, ex_branch_taken;
    logic        mem_reg_write, mem_access, mem_ready, wb_reg_write, irq;
    logic        pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, irq_take;
    logic [1:0]  forward_a, forward_b, state;
    logic [15:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(16), .DRAIN_CYCLES(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_jump         (id_jump),
        .ex_rs           (ex_rs),
        .ex_rt           (ex_rt),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_wr_reg       (ex_wr_reg),
        .ex_branch_taken (ex_branch_taken),
        .mem_reg_write   (mem_reg_write),
        .mem_wr_reg      (mem_wr_reg),
        .mem_access      (mem_access),
        .mem_ready       (mem_ready),
        .wb_reg_write    (wb_reg_write),
        .wb_wr_reg       (wb_wr_reg),
        .irq             (irq),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .pipe_hold       (pipe_hold),
        .forward_a       (forward_a),
        .forward_b       (forward_b),
        .irq_take        (irq_take),
        .state           (state),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    typedef struct {
        string      nm;
        logic [4:0] id_rs, id_rt;
        logic       uses_rt, jump;
        logic [4:0] ex_rs, ex_rt;
        logic       ld;
        logic [4:0] ex_wr;
        logic       br;
        logic       mem_rw;
        logic [4:0] mem_wr;
        logic       wb_rw;
        logic [4:0] wb_wr;
        logic       e_pc, e_ifw, chk_ifw, e_iff, e_idf;
        logic [1:0] e_fa, e_fb;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(string nm, logic [4:0] irs, logic [4:0] irt, logic urt,
                                logic jmp, logic [4:0] ers, logic [4:0] ert, logic ld,
                                logic [4:0] ewr, logic br, logic mrw, logic [4:0] mwr,
                                logic wrw, logic [4:0] wwr, logic epc, logic eifw,
                                logic cifw, logic eiff, logic eidf, logic [1:0] efa,
                                logic [1:0] efb);
        vec_t v;
        v.nm = nm; v.id_rs = irs; v.id_rt = irt; v.uses_rt = urt; v.jump = jmp;
        v.ex_rs = ers; v.ex_rt = ert; v.ld = ld; v.ex_wr = ewr; v.br = br;
        v.mem_rw = mrw; v.mem_wr = mwr; v.wb_rw = wrw; v.wb_wr = wwr;
        v.e_pc = epc; v.e_ifw = eifw; v.chk_ifw = cifw; v.e_iff = eiff; v.e_idf = eidf;
        v.e_fa = efa; v.e_fb = efb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; id_jump = 0;
        ex_rs = 0; ex_rt = 0; ex_reg_write = 0; ex_mem_read = 0; ex_wr_reg = 0;
        ex_branch_taken = 0; mem_reg_write = 0; mem_wr_reg = 0;
        mem_access = 0; mem_ready = 1; wb_reg_write = 0; wb_wr_reg = 0; irq = 0;
    endtask

    logic [15:0] s0, f0;
    int          n;
    logic        bad;

    initial begin
        //         name         irs irt urt jmp ers ert ld ewr br mrw mwr wrw wwr pc ifw cifw iff idf fa     fb
        vecs[0]  = mk("idle",     0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 2'b00, 2'b00);
        vecs[1]  = mk("fwd_mem",  0, 0, 0, 0,  5,  0, 0, 0, 0, 1, 5, 1, 5, 1, 1, 1, 0, 0, 2'b10, 2'b00);
        vecs[2]  = mk("fwd_zero", 0, 0, 0, 0,  0,  0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 1, 0, 0, 2'b00, 2'b00);
        vecs[3]  = mk("fwd_wb",   0, 0, 0, 0,  8,  8, 0, 0, 0, 0, 0, 1, 8, 1, 1, 1, 0, 0, 2'b01, 2'b01);
        vecs[4]  = mk("fwd_nowr", 0, 0, 0, 0,  0,  3, 0, 0, 0, 0, 3, 1, 3, 1, 1, 1, 0, 0, 2'b00, 2'b01);
        vecs[5]  = mk("fwd_mix",  0, 0, 0, 0,  7,  4, 0, 0, 0, 1, 4, 1, 7, 1, 1, 1, 0, 0, 2'b01, 2'b10);
        vecs[6]  = mk("lu_rs",    8, 0, 0, 0,  0,  0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        vecs[7]  = mk("lu_rt_no", 1, 8, 0, 0,  0,  0, 1, 8, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 2'b00, 2'b00);
        vecs[8]  = mk("lu_rt",    1, 8, 1, 0,  0,  0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00);
        vecs[9]  = mk("lu_zero",  0, 0, 1, 0,  0,  0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 2'b00, 2'b00);
        vecs[10] = mk("jump",     0, 0, 0, 1,  0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00);
        vecs[11] = mk("br_lu_j",  8, 0, 0, 1,  0,  0, 1, 8, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 2'b00, 2'b00);
        vecs[12] = mk("lu_j",     8, 0, 0, 1,  0,  0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00);

        // Reset values
        clear_inputs();
        reset = 1'b1;
        #3;
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_pc", 16'(pc_write), 16'd0);
        chk("rst_ifw", 16'(ifid_write), 16'd0);
        chk("rst_iff", 16'(ifid_flush), 16'd1);
        chk("rst_idf", 16'(idex_flush), 16'd1);
        chk("rst_hold", 16'(pipe_hold), 16'd0);
        chk("rst_take", 16'(irq_take), 16'd0);
        chk("rst_stall", stall_cnt, 16'd0);
        chk("rst_flush", flush_cnt, 16'd0);
        tick();
        reset = 1'b0;
        tick();

        // RUN-state combinational table
        for (int i = 0; i < 13; i++) begin
            id_rs = vecs[i].id_rs; id_rt = vecs[i].id_rt; id_uses_rt = vecs[i].uses_rt;
            id_jump = vecs[i].jump; ex_rs = vecs[i].ex_rs; ex_rt = vecs[i].ex_rt;
            ex_mem_read = vecs[i].ld; ex_reg_write = vecs[i].ld; ex_wr_reg = vecs[i].ex_wr;
            ex_branch_taken = vecs[i].br; mem_reg_write = vecs[i].mem_rw;
            mem_wr_reg = vecs[i].mem_wr; wb_reg_write = vecs[i].wb_rw;
            wb_wr_reg = vecs[i].wb_wr;
            #1;
            chk({vecs[i].nm, "_pc"}, 16'(pc_write), 16'(vecs[i].e_pc));
            if (vecs[i].chk_ifw) chk({vecs[i].nm, "_ifw"}, 16'(ifid_write), 16'(vecs[i].e_ifw));
            chk({vecs[i].nm, "_iff"}, 16'(ifid_flush), 16'(vecs[i].e_iff));
            chk({vecs[i].nm, "_idf"}, 16'(idex_flush), 16'(vecs[i].e_idf));
            chk({vecs[i].nm, "_hold"}, 16'(pipe_hold), 16'd0);
            chk({vecs[i].nm, "_fa"}, 16'(forward_a), 16'(vecs[i].e_fa));
            chk({vecs[i].nm, "_fb"}, 16'(forward_b), 16'(vecs[i].e_fb));
            tick();
            chk({vecs[i].nm, "_state"}, 16'(state), 16'd0);
        end
        clear_inputs();
        tick();

        // Load-use bubble then WB forwarding of the loaded value
        ex_mem_read = 1; ex_reg_write = 1; ex_wr_reg = 8; id_rs = 8;
        #1;
        chk("lu_seq_pc", 16'(pc_write), 16'd0);
        chk("lu_seq_idf", 16'(idex_flush), 16'd1);
        tick();
        clear_inputs();
        ex_rs = 8; wb_reg_write = 1; wb_wr_reg = 8;
        #1;
        chk("lu_seq_fa", 16'(forward_a), 16'(2'b01));
        chk("lu_seq_pc2", 16'(pc_write), 16'd1);
        tick();
        clear_inputs();

        // Data memory freeze: 4 not-ready cycles then ready
        s0 = stall_cnt;
        mem_access = 1; mem_ready = 0;
        #1;
        chk("mw_c0_state", 16'(state), 16'd0);
        chk("mw_c0_hold", 16'(pipe_hold), 16'd1);
        chk("mw_c0_pc", 16'(pc_write), 16'd0);
        tick();
        for (int c = 1; c < 4; c++) begin
            chk("mw_state", 16'(state), 16'd1);
            chk("mw_hold", 16'(pipe_hold), 16'd1);
            chk("mw_ifw", 16'(ifid_write), 16'd0);
            tick();
        end
        mem_ready = 1;
        #1;
        chk("mw_rel_state", 16'(state), 16'd1);
        chk("mw_rel_hold", 16'(pipe_hold), 16'd0);
        chk("mw_rel_pc", 16'(pc_write), 16'd1);
        tick();
        clear_inputs();
        #1;
        chk("mw_end_state", 16'(state), 16'd0);
        chk("mw_stall_cnt", stall_cnt, s0 + 16'd4);

        // Taken branch overriding a load-use hazard
        f0 = flush_cnt;
        s0 = stall_cnt;
        ex_branch_taken = 1; ex_mem_read = 1; ex_wr_reg = 9; id_rs = 9;
        #1;
        chk("br_pc", 16'(pc_write), 16'd1);
        chk("br_iff", 16'(ifid_flush), 16'd1);
        chk("br_idf", 16'(idex_flush), 16'd1);
        tick();
        clear_inputs();
        #1;
        chk("br_flush_cnt", flush_cnt, f0 + 16'd1);
        chk("br_stall_cnt", stall_cnt, s0);

        // Interrupt: pend, 3 drain cycles, one entry cycle, back to RUN
        irq = 1;
        #1;
        chk("irq_c0_state", 16'(state), 16'd0);
        tick();
        irq = 0;
        chk("irq_c1_state", 16'(state), 16'd0);
        tick();
        for (int c = 0; c < 3; c++) begin
            chk("irq_drain_state", 16'(state), 16'd2);
            chk("irq_drain_pc", 16'(pc_write), 16'd0);
            chk("irq_drain_iff", 16'(ifid_flush), 16'd1);
            chk("irq_drain_take", 16'(irq_take), 16'd0);
            tick();
        end
        chk("irq_enter_state", 16'(state), 16'd3);
        chk("irq_enter_take", 16'(irq_take), 16'd1);
        chk("irq_enter_pc", 16'(pc_write), 16'd1);
        tick();
        bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (irq_take !== 1'b0 || state !== 2'd0) bad = 1'b1;
            tick();
        end
        chk("irq_after_run", 16'(bad), 16'd0);

        // Memory stall during drain freezes the drain count
        irq = 1;
        tick();
        irq = 0;
        tick();
        chk("dstall_d0_state", 16'(state), 16'd2);
        tick();
        mem_access = 1; mem_ready = 0;
        #1;
        chk("dstall_hold", 16'(pipe_hold), 16'd1);
        tick();
        clear_inputs();
        n = 0;
        while (state == 2'd2 && n < 20) begin
            n++;
            tick();
        end
        chk("dstall_remaining", 16'(n), 16'd2);
        chk("dstall_enter", 16'(irq_take), 16'd1);
        tick();

        // Reset asserted mid-drain aborts the interrupt
        irq = 1;
        tick();
        irq = 0;
        tick();
        tick();
        chk("rd_in_drain", 16'(state), 16'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("rd_state", 16'(state), 16'd0);
        chk("rd_stall", stall_cnt, 16'd0);
        chk("rd_flush", flush_cnt, 16'd0);
        chk("rd_iff", 16'(ifid_flush), 16'd1);
        chk("rd_take", 16'(irq_take), 16'd0);
        tick();
        reset = 1'b0;
        #1;
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (irq_take !== 1'b0 || state !== 2'd0) bad = 1'b1;
            tick();
        end
        chk("rd_no_take", 16'(bad), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
